ring_osc_meter: RTL and testbench
=================================

// Module: ring_osc_meter
// PURPOSE
//  Measurement sequencer on the system clock for the ring-oscillator edge counter. Drives the
//  counter's enable for an exact gate window, then releases it. Once the count has settled it
//  reads the frozen 15-bit count through a synchronizer, confirming it with a double-read.
//  Averages 2^LOG2_AVG windows and presents the result on a valid/ready port.
// PARAMETERS
//  GATE_CYCLES   1024  clk cycles osc_en is held high per window (>=1)
//  SETTLE_CYCLES 8     clk cycles after osc_en falls before sampling starts (>=1)
//  LOG2_AVG      2     log2 of windows averaged per result (0..4)
//  MAX_RETRY     3     extra double-read attempts allowed per window before flagging an error
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   synchronous reset, active low
//  start      in   1   request one measurement; sampled only in IDLE
//  cnt_in     in   15  counter value {uio_out, uo_out[7:1]} from osc domain; async to clk
//  osc_en     out  1   counter enable, ui_in[0] of the oscillator block; registered
//  busy       out  1   high in every state except IDLE
//  res_valid  out  1   result available
//  res_ready  in   1   consumer accepts the result
//  res_count  out  15  averaged count = floor(sum / 2^LOG2_AVG)
//  res_err    out  1   at least one window exhausted its retries; its last sample was used
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): all regs clear; osc_en=0, busy=0, res_valid=0,
//   res_count=0, res_err=0; FSM goes to IDLE. Applies mid-window: osc_en falls the same edge.
//  Sync: 2-flop synchronizer on every cnt_in bit. s_prev holds the synchronized value
//   from the previous cycle.
//  FSM:
//   IDLE   : start=1 -> GATE; clear acc, win, retry, err. start=0 -> stay.
//   GATE   : osc_en=1 for exactly GATE_CYCLES cycles, counting from the first cycle after
//            start is seen -> SETTLE.
//   SETTLE : osc_en=0 for SETTLE_CYCLES cycles, then 2 more cycles to fill sync+s_prev -> SAMPLE.
//   SAMPLE : sync==s_prev -> ACCUM. Mismatch and retry<MAX_RETRY -> retry++, stay.
//            Mismatch and retry==MAX_RETRY -> err=1, use sync value -> ACCUM.
//   ACCUM  : acc += sample (acc width 15+LOG2_AVG, no overflow possible); retry=0; win++.
//            win==2^LOG2_AVG-1 before the increment -> DONE; else -> GATE.
//   DONE   : res_valid=1; res_count=acc>>LOG2_AVG and res_err are loaded on entry.
//            Both stay stable until res_valid&res_ready at an edge -> IDLE; res_valid=0 next cycle.
//  start while busy: ignored, not queued. start held high through DONE->IDLE: a new run
//   begins on the first IDLE cycle.
//  Latency, start -> res_valid, zero retries:
//   2^LOG2_AVG*(GATE_CYCLES+SETTLE_CYCLES+4)+1 cycles.
//  Each window ends with osc_en low (>= SETTLE_CYCLES+3 cycles), so the counter clears on its
//   next enable rise. The counter wraps modulo 2^15 and a wrap is undetectable here; the
//   integrator sizes GATE_CYCLES so that f_osc*T_gate < 32768.
//  res_ready while res_valid=0: no effect.
// TESTING
//  1 Reset: rst_n=0 for 3 clk -> osc_en=0, busy=0, res_valid=0, res_count=0, res_err=0.
//  2 GATE=100, LOG2_AVG=0, model drives cnt_in=1234 stable, pulse start -> osc_en high exactly
//    100 cycles; res_valid at the computed latency; res_count=1234; res_err=0.
//  3 LOG2_AVG=2, model returns 1000, 1001, 1002, 1004 on successive windows -> res_count=1001
//    (4007>>2); exactly 4 osc_en pulses.
//  4 cnt_in toggling every clk for the whole SAMPLE phase, MAX_RETRY=3 -> 4 compares, then
//    res_err=1; res_valid still asserted.
//  5 Backpressure: res_ready=0 for 50 cycles after res_valid -> res_count/res_err stable,
//    start pulses ignored; res_ready=1 -> IDLE next cycle.
//  6 rst_n=0 mid-GATE -> osc_en=0 next edge, busy=0; a fresh start afterwards yields a
//    correct result.

Source files
------------

// File: rtl/ring_osc_meter.sv
// ring_osc_meter: measurement sequencer for a ring-oscillator edge counter.
// Gates the counter enable for a fixed window, waits for the count to settle,
// reads the frozen count through a 2-flop synchronizer with a double-read
// confirmation, averages 2^LOG2_AVG windows and offers the result on a
// valid/ready port.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active low
//   start      request one measurement (sampled only in IDLE)
//   cnt_in     15-bit counter value from the oscillator domain (async)
//   osc_en     counter enable, registered
//   busy       high in every state except IDLE
//   res_valid  result available
//   res_ready  consumer accepts the result
//   res_count  averaged count, floor(sum / 2^LOG2_AVG)
//   res_err    at least one window ran out of double-read retries
module ring_osc_meter #(
    parameter int unsigned GATE_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned LOG2_AVG      = 2,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [14:0] cnt_in,
    output logic        osc_en,
    output logic        busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [14:0] res_count,
    output logic        res_err
);

    localparam int unsigned CNT_W   = 15;
    localparam int unsigned ACC_W   = CNT_W + LOG2_AVG;
    localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES + 2) ?
                                      GATE_CYCLES : SETTLE_CYCLES + 2;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned WIN_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    // Settle time plus two cycles to fill the synchronizer and s_prev
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'((32'd1 << LOG2_AVG) - 32'd1);
    localparam logic [RTY_W-1:0] RTY_LAST    = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_ACCUM,
        ST_DONE
    } state_e;

    state_e             state_q,     state_d;
    logic [TMR_W-1:0]   timer_q,     timer_d;
    logic [WIN_W-1:0]   win_q,       win_d;
    logic [RTY_W-1:0]   retry_q,     retry_d;
    logic               err_q,       err_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   sample_q,    sample_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic               res_err_q,   res_err_d;
    logic               osc_en_q,    osc_en_d;
    logic               busy_q,      busy_d;
    logic               res_valid_q, res_valid_d;

    logic [CNT_W-1:0]   sync1_q, sync2_q, s_prev_q;
    logic [ACC_W-1:0]   acc_sum;

    // Two-flop synchronizer on the count plus a one-cycle history for the double-read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            s_prev_q <= '0;
        end else begin
            sync1_q  <= cnt_in;
            sync2_q  <= sync1_q;
            s_prev_q <= sync2_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            win_q       <= '0;
            retry_q     <= '0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            sample_q    <= '0;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
            osc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            win_q       <= win_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            res_count_q <= res_count_d;
            res_err_q   <= res_err_d;
            osc_en_q    <= osc_en_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        win_d       = win_q;
        retry_d     = retry_q;
        err_d       = err_q;
        acc_d       = acc_q;
        sample_d    = sample_q;
        res_count_d = res_count_q;
        res_err_d   = res_err_q;
        acc_sum     = acc_q + ACC_W'(sample_q);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_GATE;
                    timer_d = '0;
                    acc_d   = '0;
                    win_d   = '0;
                    retry_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_GATE: begin
                if (timer_q == GATE_LAST) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (sync2_q == s_prev_q) begin
                    sample_d = sync2_q;
                    state_d  = ST_ACCUM;
                end else if (retry_q == RTY_LAST) begin
                    // Out of retries: flag it and take the latest synchronized value
                    err_d    = 1'b1;
                    sample_d = sync2_q;
                    state_d  = ST_ACCUM;
                end else begin
                    retry_d = retry_q + RTY_W'(1);
                end
            end
            ST_ACCUM: begin
                acc_d   = acc_sum;
                retry_d = '0;
                win_d   = win_q + WIN_W'(1);
                if (win_q == WIN_LAST) begin
                    state_d     = ST_DONE;
                    res_count_d = CNT_W'(acc_sum >> LOG2_AVG);
                    res_err_d   = err_q;
                end else begin
                    state_d = ST_GATE;
                    timer_d = '0;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the next state
        osc_en_d    = (state_d == ST_GATE);
        busy_d      = (state_d != ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    assign osc_en    = osc_en_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_count = res_count_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter: two instances (single-window and
// four-window averaging) driven on the falling edge and sampled there.
module tb_ring_osc_meter;

    logic        clk;
    logic        rst_n;
    logic        start0, start2;
    logic [14:0] cnt0, cnt2;
    logic        osc_en0, osc_en2;
    logic        busy0, busy2;
    logic        res_valid0, res_valid2;
    logic        ready0, ready2;
    logic [14:0] res_count0, res_count2;
    logic        res_err0, res_err2;

    int checks = 0;
    int errors = 0;
    bit tog    = 1'b0;
    logic [14:0] tbl [4];

    ring_osc_meter #(.GATE_CYCLES(100), .SETTLE_CYCLES(8), .LOG2_AVG(0), .MAX_RETRY(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cnt_in(cnt0), .osc_en(osc_en0),
        .busy(busy0), .res_valid(res_valid0), .res_ready(ready0),
        .res_count(res_count0), .res_err(res_err0)
    );

    ring_osc_meter #(.GATE_CYCLES(100), .SETTLE_CYCLES(8), .LOG2_AVG(2), .MAX_RETRY(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cnt_in(cnt2), .osc_en(osc_en2),
        .busy(busy2), .res_valid(res_valid2), .res_ready(ready2),
        .res_count(res_count2), .res_err(res_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start one measurement and watch it until res_valid; lat counts edges
    // from the one that samples start through the one that raises res_valid.
    task automatic run_meas(input bit sel, input int budget,
                            output int lat, output int hi, output int pulses);
        bit prev;
        bit o;
        int k;
        lat = -1; hi = 0; pulses = 0; prev = 1'b0; k = 0;
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            start0 = 1'b0;
            start2 = 1'b0;
            o = sel ? osc_en2 : osc_en0;
            if (o) hi++;
            if (o && !prev) begin
                pulses++;
                if (sel && k < 4) begin
                    cnt2 = tbl[k];
                    k++;
                end
            end
            prev = o;
            if (tog) cnt0 = ~cnt0;
            if (sel ? res_valid2 : res_valid0) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat, hi, pulses;
        logic [14:0] held_cnt;
        logic        held_err;
        bit          stable;
        bit          osc_seen;

        tbl[0] = 15'd1000; tbl[1] = 15'd1001; tbl[2] = 15'd1002; tbl[3] = 15'd1004;
        rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0;
        cnt0 = '0; cnt2 = '0; ready0 = 1'b0; ready2 = 1'b0;

        // Reset held for three clocks
        repeat (3) @(negedge clk);
        chk("rst_osc_en0", osc_en0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_valid0", res_valid0, 0);
        chk("rst_count0", res_count0, 0);
        chk("rst_err0", res_err0, 0);
        chk("rst_osc_en2", osc_en2, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_valid2", res_valid2, 0);
        chk("rst_count2", res_count2, 0);
        chk("rst_err2", res_err2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single window, stable count
        cnt0 = 15'd1234;
        run_meas(1'b0, 1000, lat, hi, pulses);
        chk("t2_latency", lat, 113);
        chk("t2_gate_cycles", hi, 100);
        chk("t2_pulses", pulses, 1);
        chk("t2_count", res_count0, 1234);
        chk("t2_err", res_err0, 0);
        chk("t2_busy_done", busy0, 1);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        chk("t2_drain_valid", res_valid0, 0);
        chk("t2_drain_busy", busy0, 0);

        // Four-window average of 1000,1001,1002,1004
        cnt2 = tbl[0];
        run_meas(1'b1, 1000, lat, hi, pulses);
        chk("t3_latency", lat, 449);
        chk("t3_gate_cycles", hi, 400);
        chk("t3_pulses", pulses, 4);
        chk("t3_count", res_count2, 1001);
        chk("t3_err", res_err2, 0);
        ready2 = 1'b1;
        @(negedge clk);
        ready2 = 1'b0;
        chk("t3_drain_valid", res_valid2, 0);

        // Count toggling every clock: four failed compares then error
        cnt0 = 15'h2AAA;
        tog  = 1'b1;
        run_meas(1'b0, 1000, lat, hi, pulses);
        tog  = 1'b0;
        chk("t4_latency", lat, 116);
        chk("t4_err", res_err0, 1);
        chk("t4_valid", res_valid0, 1);

        // Backpressure with ignored start pulses
        held_cnt = res_count0;
        held_err = res_err0;
        stable   = 1'b1;
        osc_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            start0 = (i % 10 == 3);
            @(negedge clk);
            if (res_count0 !== held_cnt || res_err0 !== held_err || res_valid0 !== 1'b1)
                stable = 1'b0;
            if (osc_en0) osc_seen = 1'b1;
        end
        start0 = 1'b0;
        chk("t5_stable", stable, 1);
        chk("t5_no_gate", osc_seen, 0);
        chk("t5_busy", busy0, 1);
        chk("t5_err_held", res_err0, 1);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        chk("t5_valid_drop", res_valid0, 0);
        chk("t5_idle", busy0, 0);

        // Reset in the middle of a gate window, then a clean run
        cnt0   = 15'd555;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (19) @(negedge clk);
        chk("t6_mid_gate", osc_en0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_osc_en", osc_en0, 0);
        chk("t6_rst_busy", busy0, 0);
        chk("t6_rst_valid", res_valid0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_meas(1'b0, 1000, lat, hi, pulses);
        chk("t6_latency", lat, 113);
        chk("t6_count", res_count0, 555);
        chk("t6_err", res_err0, 0);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        chk("t6_drain_valid", res_valid0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
